// File: rtl/adc_spi_sampler.sv
// SPI mode-0 front end for a serial ADC: one conversion per sample period,
// presented as a parallel word plus a mid-period sample clock.
module adc_spi_sampler #(
    parameter int CLK_DIV    = 10,
    parameter int SAMPLE_DIV = 1000,
    parameter int LEAD_BITS  = 3,
    parameter int DATA_BITS  = 12,
    parameter bit TWOS_COMP  = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 adc_miso,
    output logic                 adc_sck,
    output logic                 adc_cs_n,
    output logic [DATA_BITS-1:0] sample_data,
    output logic                 sample_valid,
    output logic                 sample_clk
);

    localparam int N  = LEAD_BITS + DATA_BITS;
    localparam int CW = $clog2(SAMPLE_DIV);
    localparam int HW = $clog2(CLK_DIV + 1);
    localparam int BW = $clog2(N + 1);

    localparam logic [CW-1:0] CNT_MAX  = CW'(SAMPLE_DIV - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(SAMPLE_DIV / 2);
    localparam logic [HW-1:0] HC_MAX   = HW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_N    = BW'(N);

    if ((SAMPLE_DIV % 2) != 0) begin : g_odd_div
        $error("SAMPLE_DIV must be even");
    end

    // The word must be settled before sample_clk rises mid-period.
    if (CLK_DIV * (2 * N + 2) + 2 >= SAMPLE_DIV / 2) begin : g_slow_spi
        $error("SPI transaction does not fit in half a sample period");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_LOW,
        S_HIGH,
        S_TAIL,
        S_DONE
    } state_t;

    state_t                r_state;
    logic [CW-1:0]         r_cnt;
    logic                  r_sclk;
    logic [HW-1:0]         r_hc;
    logic [BW-1:0]         r_bits;
    logic [DATA_BITS-1:0]  r_sr;
    logic                  r_sck;
    logic                  r_cs_n;
    logic [DATA_BITS-1:0]  r_data;
    logic                  r_valid;

    logic [CW-1:0]         w_cnt_nxt;
    logic                  w_hc_end;
    logic [DATA_BITS-1:0]  w_word;

    assign w_cnt_nxt = (r_cnt == CNT_MAX) ? '0 : r_cnt + CW'(1);
    assign w_hc_end  = (r_hc == HC_MAX);
    assign w_word    = r_sr ^ {TWOS_COMP, {(DATA_BITS-1){1'b0}}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_sclk <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_sclk <= (w_cnt_nxt >= CNT_HALF);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_hc    <= '0;
            r_bits  <= '0;
            r_sr    <= '0;
            r_sck   <= 1'b0;
            r_cs_n  <= 1'b1;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (r_cnt == '0 && enable) begin
                        r_state <= S_SETUP;
                        r_cs_n  <= 1'b0;
                        r_hc    <= '0;
                        r_bits  <= '0;
                    end
                end
                S_SETUP: begin
                    r_hc <= w_hc_end ? '0 : r_hc + HW'(1);
                    if (w_hc_end) begin
                        r_state <= S_LOW;
                    end
                end
                S_LOW: begin
                    r_hc <= w_hc_end ? '0 : r_hc + HW'(1);
                    if (w_hc_end) begin
                        r_state <= S_HIGH;
                        r_sck   <= 1'b1;
                        r_sr    <= {r_sr[DATA_BITS-2:0], adc_miso};
                        r_bits  <= r_bits + BW'(1);
                    end
                end
                S_HIGH: begin
                    r_hc <= w_hc_end ? '0 : r_hc + HW'(1);
                    if (w_hc_end) begin
                        r_sck   <= 1'b0;
                        r_state <= (r_bits == BIT_N) ? S_TAIL : S_LOW;
                    end
                end
                S_TAIL: begin
                    r_hc <= w_hc_end ? '0 : r_hc + HW'(1);
                    if (w_hc_end) begin
                        r_state <= S_DONE;
                        r_cs_n  <= 1'b1;
                        r_data  <= w_word;
                        r_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_sck   <= 1'b0;
                    r_cs_n  <= 1'b1;
                end
            endcase
        end
    end

    assign adc_sck      = r_sck;
    assign adc_cs_n     = r_cs_n;
    assign sample_data  = r_data;
    assign sample_valid = r_valid;
    assign sample_clk   = r_sclk;

endmodule

// File: tb/tb_adc_spi_sampler.sv
// Bench for adc_spi_sampler: a cycle-level timing model from the period
// arithmetic, an ADC word model, vector table, corner sequences, random.
module tb_adc_spi_sampler;

    localparam int SD  = 1000;
    localparam int CD  = 10;
    localparam int NB  = 15;
    localparam int RDY = CD * (2 * NB + 2) + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        miso;
    logic        sck0, cs0, v0, sc0;
    logic        sck1, cs1, v1, sc1;
    logic [11:0] d0, d1;

    int checks = 0;
    int errs   = 0;

    always #10 clk = ~clk;

    adc_spi_sampler #(.TWOS_COMP(1'b0)) u0 (
        .clk(clk), .rst(rst), .enable(enable), .adc_miso(miso),
        .adc_sck(sck0), .adc_cs_n(cs0), .sample_data(d0),
        .sample_valid(v0), .sample_clk(sc0)
    );

    adc_spi_sampler #(.TWOS_COMP(1'b1)) u1 (
        .clk(clk), .rst(rst), .enable(enable), .adc_miso(miso),
        .adc_sck(sck1), .adc_cs_n(cs1), .sample_data(d1),
        .sample_valid(v1), .sample_clk(sc1)
    );

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errs++;
            $display("FAIL %s got %0h want %0h at %0t",
                     nm, got, want, $time);
        end
    endtask

    // ADC: first bit out when CS falls, next bit after each SCK fall.
    logic [14:0] word_q[$];
    logic [14:0] adc_word = '0;
    logic [14:0] cur_word = '0;
    int          adc_idx  = 0;

    always @(negedge cs0) begin
        if (word_q.size() > 0) adc_word = word_q.pop_front();
        else adc_word = '0;
        cur_word = adc_word;
        adc_idx  = 0;
        miso     = adc_word[14];
    end

    always @(negedge sck0) begin
        if (cs0 === 1'b0) begin
            adc_idx++;
            miso = (adc_idx < NB) ? adc_word[NB-1-adc_idx] : 1'b0;
        end
    end

    // Reference: n = clocks since reset release, phase = n mod SD.
    int          n     = 0;
    bit          m_act = 1'b0;
    logic [11:0] m_d0  = '0;
    logic [11:0] m_d1  = '0;
    bit          mon_on = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            n     <= 0;
            m_act <= 1'b0;
            m_d0  <= '0;
            m_d1  <= '0;
        end else begin
            if (n % SD == 0) m_act <= enable;
            n <= n + 1;
            if (m_act && ((n + 1) % SD == RDY)) begin
                m_d0 <= cur_word[11:0];
                m_d1 <= cur_word[11:0] ^ 12'h800;
            end
        end
    end

    function automatic logic [3:0] exp_ctl(input int c, input bit act);
        logic e_cs, e_sck, e_v, e_sc;
        e_cs  = !(act && c >= 1 && c <= RDY - 1);
        e_sck = act && c >= 2*CD + 1 && c <= 2*CD*NB + CD
                && ((c - 2*CD - 1) % (2*CD)) < CD;
        e_v   = act && c == RDY;
        e_sc  = c >= SD / 2;
        return {e_cs, e_sck, e_v, e_sc};
    endfunction

    always @(negedge clk) begin
        if (mon_on) begin
            chk("ctl0", {28'd0, cs0, sck0, v0, sc0},
                {28'd0, exp_ctl(n % SD, m_act)});
            chk("ctl1", {28'd0, cs1, sck1, v1, sc1},
                {28'd0, exp_ctl(n % SD, m_act)});
            chk("mdata0", {20'd0, d0}, {20'd0, m_d0});
            chk("mdata1", {20'd0, d1}, {20'd0, m_d1});
        end
    end

    task automatic run(input int len, output int rises, output int gbad,
                       output int vcnt, output int cslo,
                       output int schi, output int scr);
        logic ps, pc;
        int   last, lastc;
        ps = sck0; pc = sc0; last = -1; lastc = -1;
        rises = 0; gbad = 0; vcnt = 0; cslo = 0; schi = 0; scr = 0;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            if (sck0 && !ps) begin
                rises++;
                if (last >= 0 && i - last != 2*CD) gbad++;
                last = i;
            end
            if (sc0 && !pc) begin
                scr++;
                if (lastc >= 0 && i - lastc != SD) gbad++;
                lastc = i;
            end
            ps = sck0;
            pc = sc0;
            vcnt += int'(v0);
            cslo += int'(!cs0);
            schi += int'(sc0);
        end
    endtask

    typedef struct {
        logic [2:0]  lead;
        logic [11:0] data;
        logic [11:0] exp0;
        logic [11:0] exp1;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int rs, gb, vc, cl, sh, sr;
        int r;
        bit act, act_next;
        logic [14:0] wn, wcur;
        logic [11:0] rexp;

        tbl[0] = '{3'b000, 12'hA5C, 12'hA5C, 12'h25C};
        tbl[1] = '{3'b000, 12'h800, 12'h800, 12'h000};
        tbl[2] = '{3'b000, 12'h7FF, 12'h7FF, 12'hFFF};
        tbl[3] = '{3'b111, 12'h123, 12'h123, 12'h923};
        tbl[4] = '{3'b101, 12'hFFF, 12'hFFF, 12'h7FF};
        tbl[5] = '{3'b010, 12'h000, 12'h000, 12'h800};

        rst = 1'b1; enable = 1'b0; miso = 1'b0;
        repeat (3) @(negedge clk);
        mon_on = 1'b1;
        chk("rst_vals", {15'd0, cs0, sck0, v0, sc0, d0},
            {15'd0, 4'b1000, 12'h000});

        for (int k = 0; k < 6; k++)
            word_q.push_back({tbl[k].lead, tbl[k].data});
        word_q.push_back({3'b000, 12'h3C5});
        enable = 1'b1;
        @(negedge clk); #2 rst = 1'b0;

        for (int k = 0; k < 6; k++) begin
            run(SD, rs, gb, vc, cl, sh, sr);
            chk("rises", rs, NB);
            chk("gaps", gb, 0);
            chk("vcnt", vc, 1);
            chk("cs_low", cl, RDY - 1);
            chk("tbl_d0", {20'd0, d0}, {20'd0, tbl[k].exp0});
            chk("tbl_d1", {20'd0, d1}, {20'd0, tbl[k].exp1});
        end

        // Drop enable at phase 100: transaction still completes.
        run(100, rs, gb, vc, cl, sh, sr);
        enable = 1'b0;
        run(SD - 100, rs, gb, vc, cl, sh, sr);
        chk("drop_vcnt", vc, 1);
        chk("drop_d0", {20'd0, d0}, {20'd0, 12'h3C5});
        chk("drop_d1", {20'd0, d1}, {20'd0, 12'hBC5});
        run(SD, rs, gb, vc, cl, sh, sr);
        chk("idle_cs", cl, 0);
        chk("idle_v", vc, 0);
        chk("hold_d0", {20'd0, d0}, {20'd0, 12'h3C5});

        // Reset with enable low: only sample_clk moves.
        @(negedge clk); #2 rst = 1'b1;
        #1 chk("rst_d0", {20'd0, d0}, 32'd0);
        @(negedge clk); #2 rst = 1'b0;
        run(5 * SD, rs, gb, vc, cl, sh, sr);
        chk("off_cs", cl, 0);
        chk("off_sck", rs, 0);
        chk("off_sc_hi", sh, 5 * SD / 2);
        chk("off_sc_rise", sr, 5);
        chk("off_sc_gap", gb, 0);
        chk("off_d0", {20'd0, d0}, 32'd0);

        // Reset in the middle of the shift.
        word_q.push_back({3'b000, 12'h5A5});
        word_q.push_back({3'b000, 12'hF0F});
        word_q.push_back({3'b000, 12'h6B6});
        enable = 1'b1;
        run(SD, rs, gb, vc, cl, sh, sr);
        chk("pre_d0", {20'd0, d0}, {20'd0, 12'h5A5});
        run(205, rs, gb, vc, cl, sh, sr);
        chk("pre_rst", {30'd0, cs0, sck0}, {30'd0, 2'b01});
        #2 rst = 1'b1;
        #1 chk("async_rst", {14'd0, cs0, sck0, v0, sc0, d0, d1},
               {14'd0, 4'b1000, 12'h000, 12'h000});
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        run(1, rs, gb, vc, cl, sh, sr);
        chk("fresh_cs", {31'd0, cs0}, 32'd0);
        run(499, rs, gb, vc, cl, sh, sr);
        chk("fresh_v", vc, 1);
        enable = 1'b0;
        run(SD - 500, rs, gb, vc, cl, sh, sr);
        chk("fresh_d0", {20'd0, d0}, {20'd0, 12'h6B6});

        // Random words and random enable per period.
        rexp = 12'h6B6;
        act_next = 1'b0;
        wn = '0;
        for (int p = 0; p < 12; p++) begin
            act  = act_next;
            wcur = wn;
            act_next = ($urandom_range(0, 3) != 0);
            wn = 15'($urandom);
            if (act_next) word_q.push_back(wn);
            r = $urandom_range(1, SD - 2);
            run(r, rs, gb, vc, cl, sh, sr);
            enable = act_next;
            run(SD - r, rs, gb, vc, cl, sh, sr);
            if (act) rexp = wcur[11:0];
            chk("rnd_d0", {20'd0, d0}, {20'd0, rexp});
            chk("rnd_d1", {20'd0, d1}, {20'd0, rexp ^ 12'h800});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errs);
        $finish;
    end

endmodule

// File: doc/adc_spi_sampler.md
Name: adc_spi_sampler

Overview:
- Front end of the audio path. Runs a 12-bit serial ADC over SPI (mode 0) once per sample period.
- Presents each conversion as a parallel 12-bit word, together with a derived 50 kHz sample clock whose rising edge falls mid-period, when the word is stable.
- Directly feeds the downstream FIR filter's 12-bit sample input and its 50 kHz clock input.

Parameters:
- CLK_DIV, 10: system clocks per SCK half-period (50 MHz / 20 = 2.5 MHz SCK).
- SAMPLE_DIV, 1000: system clocks per sample period (50 MHz / 1000 = 50 kHz). Must be even.
- LEAD_BITS, 3: SCK cycles clocked before the data MSB (sample/null bits); their MISO values are discarded.
- DATA_BITS, 12: conversion width, MSB first.
- TWOS_COMP, 0: 0 = output straight binary as received; 1 = invert the output MSB (offset-binary to two's complement).

Ports:
- clk, input, 1: system clock, 50 MHz.
- rst, input, 1: asynchronous, active-high reset.
- enable, input, 1: when high, a transaction starts at each period boundary.
- adc_miso, input, 1: ADC serial data. Changes after SCK falls; sampled when SCK rises.
- adc_sck, output, 1: SPI clock. Idles low.
- adc_cs_n, output, 1: ADC chip select, active low.
- sample_data, output, DATA_BITS: last completed conversion.
- sample_valid, output, 1: one-clk pulse when sample_data updates.
- sample_clk, output, 1: 50% duty clock at clk/SAMPLE_DIV, for the filter.

Behaviour:
- Reset (asynchronous, any time, including mid-transaction):
  - adc_cs_n=1, adc_sck=0, sample_data=0, sample_valid=0, sample_clk=0.
  - Period counter=0, FSM=IDLE, shift register=0, bit counter=0.
  - An in-flight transaction is abandoned; no partial word is ever output.
- Period counter: counts 0..SAMPLE_DIV-1 and wraps. It runs regardless of enable.
- sample_clk: registered; equals 1 while counter >= SAMPLE_DIV/2. Its first rising edge after reset release comes SAMPLE_DIV/2 clks later.
- Transaction start: the FSM leaves IDLE when counter==0, enable==1 and the FSM is in IDLE.
  - enable is sampled only at counter==0.
  - Dropping enable mid-transaction does not abort; the transaction completes.
- Let N = LEAD_BITS+DATA_BITS.
- FSM states (registered outputs; a half-period counter hc runs 0..CLK_DIV-1):
  - IDLE: cs_n=1, sck=0.
  - SETUP: cs_n=0, sck=0, for CLK_DIV clks (CS-to-first-edge setup).
  - LOW: sck=0, for CLK_DIV clks.
  - HIGH: sck=1, for CLK_DIV clks. On the clk where LOW->HIGH is entered, shift in adc_miso (sr <= {sr, miso}) and increment the bit counter.
  - HIGH -> LOW while the bit count < N; HIGH -> TAIL after bit N.
  - TAIL: sck=0, cs_n=0, for CLK_DIV clks. Then -> DONE.
  - DONE (1 clk): cs_n=1. sample_data <= low DATA_BITS of sr, with MSB inverted if TWOS_COMP. sample_valid=1. Then -> IDLE.
- Leading-bit handling: the first LEAD_BITS shifted bits are discarded by width truncation only.
- Timing:
  - cs_n falls at counter=1 (output registered, one clk after the counter==0 decision).
  - Transaction occupies CLK_DIV*(2N+2)+1 clks; with defaults 321 clks, so sample_valid asserts at counter=321.
- Required constraint: CLK_DIV*(2N+2)+2 < SAMPLE_DIV/2, so sample_data is stable before sample_clk rises. Check at elaboration; defaults satisfy it (322 < 500).
- sample_data holds its value between valid pulses. When enable is low it retains the last word, and sample_clk keeps toggling.
- adc_miso is used raw. The top level places it in an IOB flop or ensures setup to clk; each bit is stable for ≥ CLK_DIV clks around its sampling edge.
- No back-pressure; the consumer must accept each word before the next sample_valid.

Test Plan:
- Reset release, enable=1, ADC model returns 3 lead zeros then 0xA5C:
  - cs_n falls at counter=1.
  - Exactly 15 SCK rising edges, each 20 clks apart.
  - sample_valid single pulse at counter=321.
  - sample_data=0xA5C.
  - sample_clk rises at counter=500.
- TWOS_COMP=1, ADC returns 0x800 then 0x7FF -> sample_data=0x000, then 0xFFF on consecutive periods.
- enable=0 from reset:
  - No cs_n/sck activity for 5 periods.
  - sample_clk toggles with period 1000, duty 500/500.
  - sample_data=0.
- enable deasserted at counter=100 of an active transaction:
  - That transaction completes with its valid pulse.
  - No transaction starts at the next counter==0.
- rst pulsed at counter=200 (mid-shift):
  - cs_n=1 and sck=0 immediately (asynchronous).
  - sample_data=0, no valid pulse.
  - A fresh transaction begins at counter=1 after release.
- Leading-bit masking: ADC drives lead bits as 1s with data 0x123 -> sample_data=0x123.
